// File: rtl/nap_setter_pkg.sv
// Shared types and constants for the nap timer keypad time setter.
package nap_setter_pkg;

    localparam int BCD_W = 4;
    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [BCD_W-1:0] ten_min;
        logic [BCD_W-1:0] one_min;
        logic [BCD_W-1:0] ten_sec;
        logic [BCD_W-1:0] one_sec;
    } bcd_time_t;

    // Seconds added per key; entry 0 is the clear key and adds nothing.
    localparam cnt_t KEY_INC_SEC [0:9] = '{
        11'd0, 11'd5, 11'd30, 11'd60, 11'd120,
        11'd300, 11'd600, 11'd900, 11'd1200, 11'd1800
    };

endpackage

// File: rtl/bcd_time_inc.sv
// Combinational +1 second on a BCD mm:ss value, holding at the MAX_MIN:59 ceiling.
module bcd_time_inc
    import nap_setter_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  bcd_time_t cur,
    output bcd_time_t nxt,
    output logic      sat
);

    localparam logic [BCD_W-1:0] MAX_TEN = 4'(MAX_MIN / 10);
    localparam logic [BCD_W-1:0] MAX_ONE = 4'(MAX_MIN % 10);

    always_comb begin
        sat = (cur.ten_min == MAX_TEN) && (cur.one_min == MAX_ONE) &&
              (cur.ten_sec == 4'd5) && (cur.one_sec == 4'd9);
        nxt = cur;
        if (!sat) begin
            if (cur.one_sec != 4'd9) begin
                nxt.one_sec = cur.one_sec + 4'd1;
            end else begin
                nxt.one_sec = 4'd0;
                if (cur.ten_sec != 4'd5) begin
                    nxt.ten_sec = cur.ten_sec + 4'd1;
                end else begin
                    nxt.ten_sec = 4'd0;
                    if (cur.one_min != 4'd9) begin
                        nxt.one_min = cur.one_min + 4'd1;
                    end else begin
                        nxt.one_min = 4'd0;
                        nxt.ten_min = cur.ten_min + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/nap_time_setter.sv
// Keypad time setter: one-hot key presses add preset seconds to a BCD mm:ss value.
// Optional NAP_KEY_REPEAT_EN adds auto-repeat of a held add key while idle.
module nap_time_setter
    import nap_setter_pkg::*;
#(
    parameter int NUM_KEYS      = 10,
    parameter int MAX_MIN       = 99,
    parameter int REPEAT_CYCLES = 50000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sharp,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic                completeSetting,
    output logic                busy,
    output logic [BCD_W-1:0]    one_sec,
    output logic [BCD_W-1:0]    ten_sec,
    output logic [BCD_W-1:0]    one_min,
    output logic [BCD_W-1:0]    ten_min
);

    localparam logic [NUM_KEYS-1:0] KEY_ONE = NUM_KEYS'(1);

    state_t              state, next_state;
    cnt_t                cnt, next_cnt;
    bcd_time_t           cur_time, next_time, inc_time;
    logic                sat;
    logic [NUM_KEYS-1:0] keypad_q;
    logic                sharp_q;
    logic [3:0]          key_idx;
    logic                single, key_ev, clear_ev, add_ev, sharp_ev, time_zero;

    bcd_time_inc #(.MAX_MIN(MAX_MIN)) u_inc (
        .cur (cur_time),
        .nxt (inc_time),
        .sat (sat)
    );

    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keypad[i]) key_idx = 4'(i);
        end
    end

    // A key event needs exactly one line high now, and that line low last cycle.
    assign single    = (keypad != '0) && ((keypad & (keypad - KEY_ONE)) == '0);
    assign key_ev    = single && ((keypad & ~keypad_q) != '0);
    assign clear_ev  = key_ev && (key_idx == 4'd0);
    assign sharp_ev  = sharp && !sharp_q;
    assign time_zero = (cur_time == '0);

`ifdef NAP_KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    logic [REP_W-1:0] rep_cnt;
    logic             held, rep_fire;

    assign held     = single && (keypad == keypad_q) && (key_idx != 4'd0) && (state == IDLE);
    assign rep_fire = held && (rep_cnt == REP_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !held || rep_fire) rep_cnt <= '0;
        else                            rep_cnt <= rep_cnt + REP_W'(1);
    end

    assign add_ev = (key_ev && (key_idx != 4'd0)) || rep_fire;
`else
    assign add_ev = key_ev && (key_idx != 4'd0);
`endif

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_time  = cur_time;
        if (clear_ev) begin
            next_state = IDLE;
            next_cnt   = '0;
            next_time  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (add_ev) begin
                        next_cnt   = KEY_INC_SEC[key_idx];
                        next_state = ADD;
                    end else if (sharp_ev && !time_zero) begin
                        next_state = DONE;
                    end
                end
                ADD: begin
                    if (sat) begin
                        next_cnt   = '0;
                        next_state = IDLE;
                    end else begin
                        next_time = inc_time;
                        next_cnt  = cnt - cnt_t'(1);
                        if (cnt <= cnt_t'(1)) next_state = IDLE;
                    end
                end
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_time <= '0;
            keypad_q <= '0;
            sharp_q  <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            cur_time <= next_time;
            keypad_q <= keypad;
            sharp_q  <= sharp;
        end
    end

    assign busy            = (state == ADD);
    assign completeSetting = (state == DONE);
    assign one_sec         = cur_time.one_sec;
    assign ten_sec         = cur_time.ten_sec;
    assign one_min         = cur_time.one_min;
    assign ten_min         = cur_time.ten_min;

endmodule
